// File: rtl/dcache_arb_pkg.sv
// Shared types and constants for the data-cache port arbiter.
// Port indices name the fixed requester roles in the core.
package dcache_arb_pkg;

    localparam int NR_PORTS_DEF = 3;
    localparam int PORT_IDX_W   = $clog2(NR_PORTS_DEF);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    localparam port_idx_t PORT_PTW  = port_idx_t'(0);
    localparam port_idx_t PORT_LOAD = port_idx_t'(1);
    localparam port_idx_t PORT_VLSU = port_idx_t'(2);

    // (base + off) modulo n, with base < n and off < n
    function automatic int rr_wrap(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Bundle of the requester-side, memory-side and response signals of the
// dcache port arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding requesters and cache.
interface dcache_port_arbiter_if #(
    parameter int NrPorts   = 3,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic [NrPorts-1:0]             req_valid_i;
    logic [NrPorts*AddrWidth-1:0]   req_addr_i;
    logic [NrPorts-1:0]             req_we_i;
    logic [NrPorts*DataWidth/8-1:0] req_be_i;
    logic [NrPorts*DataWidth-1:0]   req_wdata_i;
    logic [NrPorts-1:0]             req_gnt_o;

    logic                           mem_req_o;
    logic [AddrWidth-1:0]           mem_addr_o;
    logic                           mem_we_o;
    logic [DataWidth/8-1:0]         mem_be_o;
    logic [DataWidth-1:0]           mem_wdata_o;
    logic                           mem_gnt_i;
    logic                           mem_rvalid_i;
    logic [DataWidth-1:0]           mem_rdata_i;

    logic [NrPorts-1:0]             rsp_valid_o;
    logic [DataWidth-1:0]           rsp_rdata_o;
    logic                           orphan_rsp_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
        output req_gnt_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output rsp_valid_o, rsp_rdata_o, orphan_rsp_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
        input  req_gnt_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  rsp_valid_o, rsp_rdata_o, orphan_rsp_o
    );

endinterface

// File: rtl/dcache_arb_id_fifo.sv
// In-order FIFO of requester indices for reads still waiting on a response.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module dcache_arb_id_fifo
    import dcache_arb_pkg::*;
#(
    parameter int  Depth   = 2,
    parameter type entry_t = port_idx_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    entry_t          r_mem [Depth];
    logic [PtrW-1:0] r_rptr;
    logic [PtrW-1:0] r_wptr;
    logic [CntW-1:0] r_cnt;
    logic            w_pop;
    logic            w_push;

    assign full_o  = (r_cnt == CntW'(Depth));
    assign empty_o = (r_cnt == '0);
    assign head_o  = r_mem[r_rptr];
    assign w_pop   = pop_i & ~empty_o;
    assign w_push  = push_i & (~full_o | w_pop);

    // Storage: entries need no reset, the count decides which are live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointers and occupancy count, wrapping at Depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PtrW'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one write-through dcache port between the
// PTW, the load unit and the vector load/store unit. Granted reads are
// remembered in issue order so responses can be steered back to their
// requester; a response with nothing outstanding is flagged and dropped.
// Optional: define DCACHE_PORT_ARBITER_PERF_EN to add conflict_cnt_o, a
// saturating count of cycles where several ports contend and one loses.
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int NrPorts        = 3,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dcache_port_arbiter_if.slave  bus
`ifdef DCACHE_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]           conflict_cnt_o
`endif
);
    localparam int IdxW = $clog2(NrPorts);
    localparam int BeW  = DataWidth / 8;

    typedef logic [IdxW-1:0] idx_t;

    idx_t                 r_rr;
    idx_t                 w_win;
    logic                 w_any;
    logic                 w_we;
    logic                 w_xfer;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    idx_t                 w_head;

    // Winner: first valid port at or after the round-robin pointer.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < NrPorts; k++) begin
            if (!w_any && bus.req_valid_i[rr_wrap(int'(r_rr), k, NrPorts)]) begin
                w_any = 1'b1;
                w_win = idx_t'(rr_wrap(int'(r_rr), k, NrPorts));
            end
        end
    end

    // Downstream fields mirror the winner; all zero when nobody is valid.
    always_comb begin
        bus.mem_addr_o  = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        if (w_any) begin
            bus.mem_addr_o  = bus.req_addr_i[int'(w_win)*AddrWidth +: AddrWidth];
            bus.mem_we_o    = bus.req_we_i[w_win];
            bus.mem_be_o    = bus.req_be_i[int'(w_win)*BeW +: BeW];
            bus.mem_wdata_o = bus.req_wdata_i[int'(w_win)*DataWidth +: DataWidth];
        end
    end

    assign w_we = bus.mem_we_o;

    // Reads wait for a free ID slot; a same-cycle response frees one.
    // Writes produce no response and so never wait on the FIFO.
    always_comb begin
        bus.mem_req_o = w_any & (w_we | ~w_full | bus.mem_rvalid_i);
        w_xfer        = bus.mem_req_o & bus.mem_gnt_i;
        w_push        = w_xfer & ~w_we;
        w_pop         = bus.mem_rvalid_i & ~w_empty;
        bus.req_gnt_o = '0;
        if (w_xfer) begin
            bus.req_gnt_o[w_win] = 1'b1;
        end
    end

    // Response steering to the oldest outstanding reader.
    always_comb begin
        bus.rsp_valid_o  = '0;
        bus.rsp_rdata_o  = '0;
        bus.orphan_rsp_o = bus.mem_rvalid_i & w_empty;
        if (w_pop) begin
            bus.rsp_valid_o[w_head] = 1'b1;
            bus.rsp_rdata_o         = bus.mem_rdata_i;
        end
    end

    // Pointer advances past a granted winner; an ungranted winner keeps it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (w_xfer) begin
            r_rr <= (int'(w_win) == NrPorts - 1) ? '0 : w_win + 1'b1;
        end
    end

    dcache_arb_id_fifo #(
        .Depth   (MaxOutstanding),
        .entry_t (idx_t)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_win),
        .pop_i   (w_pop),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

`ifdef DCACHE_PORT_ARBITER_PERF_EN
    logic [31:0] r_conflict;
    logic        w_conflict;

    assign w_conflict = ($countones(bus.req_valid_i) >= 2) &&
                        ((bus.req_valid_i & ~bus.req_gnt_o) != '0);
    assign conflict_cnt_o = r_conflict;

    // Saturating contention counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflict <= '0;
        end else if (w_conflict && (r_conflict != '1)) begin
            r_conflict <= r_conflict + 32'd1;
        end
    end
`endif

    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && w_full && !w_pop));

    a_gnt_onehot : assert property (@(posedge clk_i) $onehot0(bus.req_gnt_o));

    for (genvar p = 0; p < NrPorts; p++) begin : g_stable
        a_req_stable : assert property (@(posedge clk_i)
            (!rst_i && bus.req_valid_i[p] && !bus.req_gnt_o[p]) |=>
            (rst_i || (bus.req_valid_i[p] &&
                       $stable(bus.req_addr_i[p*AddrWidth +: AddrWidth]) &&
                       $stable(bus.req_we_i[p]) &&
                       $stable(bus.req_be_i[p*BeW +: BeW]) &&
                       $stable(bus.req_wdata_i[p*DataWidth +: DataWidth]))));
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a per-cycle vector table plus
// hand-written sequences for grant latency and the optional perf counter.
module tb_dcache_port_arbiter;
    import dcache_arb_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk_i = ~clk_i;

    dcache_port_arbiter_if #(.NrPorts(3), .AddrWidth(64), .DataWidth(64)) bus ();

`ifdef DCACHE_PORT_ARBITER_PERF_EN
    logic [31:0] conflict_cnt;
`endif

    dcache_port_arbiter #(
        .NrPorts(3), .AddrWidth(64), .DataWidth(64), .MaxOutstanding(2)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
`ifdef DCACHE_PORT_ARBITER_PERF_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [2:0]  we;
        logic        gnt;
        logic        rvalid;
        logic [63:0] rdata;
        int          e_port;
        logic [2:0]  e_gnt;
        logic        e_req;
        logic [2:0]  e_rsp;
        logic [63:0] e_rdata;
        logic        e_orphan;
    } vec_t;

    localparam int NV = 26;
    vec_t tv [NV];

    logic [63:0] addr_c  [3];
    logic [7:0]  be_c    [3];
    logic [63:0] wdata_c [3];

    function automatic vec_t mk(logic r, logic [2:0] v, logic [2:0] w, logic g,
                                logic rv, logic [63:0] rd, int ep, logic [2:0] eg,
                                logic er, logic [2:0] ers, logic [63:0] erd, logic eo);
        vec_t t;
        t.rst = r; t.valid = v; t.we = w; t.gnt = g; t.rvalid = rv; t.rdata = rd;
        t.e_port = ep; t.e_gnt = eg; t.e_req = er; t.e_rsp = ers;
        t.e_rdata = erd; t.e_orphan = eo;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout row 0: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int dly;
        int got;

        for (int p = 0; p < 3; p++) begin
            addr_c[p]  = 64'h1000 * 64'(p + 1);
            wdata_c[p] = 64'hA0A0_0000_0000_0000 + 64'(p);
        end
        be_c[0] = 8'h0F; be_c[1] = 8'hF0; be_c[2] = 8'hFF;

        //            rst valid   we     gnt rv rdata         port gnt    req rsp    rdata         orph
        tv[0]  = mk(0, 3'b000, 3'b000, 1, 0, 64'h0,        -1, 3'b000, 0, 3'b000, 64'h0,        0);
        tv[1]  = mk(0, 3'b111, 3'b000, 1, 0, 64'h0,         0, 3'b001, 1, 3'b000, 64'h0,        0);
        tv[2]  = mk(0, 3'b111, 3'b000, 1, 1, 64'h11,        1, 3'b010, 1, 3'b001, 64'h11,       0);
        tv[3]  = mk(0, 3'b111, 3'b000, 1, 1, 64'h22,        2, 3'b100, 1, 3'b010, 64'h22,       0);
        tv[4]  = mk(0, 3'b111, 3'b000, 1, 1, 64'h33,        0, 3'b001, 1, 3'b100, 64'h33,       0);
        tv[5]  = mk(0, 3'b110, 3'b000, 1, 1, 64'h44,        1, 3'b010, 1, 3'b001, 64'h44,       0);
        tv[6]  = mk(0, 3'b100, 3'b000, 1, 0, 64'h0,         2, 3'b100, 1, 3'b000, 64'h0,        0);
        tv[7]  = mk(0, 3'b001, 3'b000, 1, 0, 64'h0,         0, 3'b000, 0, 3'b000, 64'h0,        0);
        tv[8]  = mk(0, 3'b001, 3'b000, 1, 1, 64'hDEADBEEF,  0, 3'b001, 1, 3'b010, 64'hDEADBEEF, 0);
        tv[9]  = mk(0, 3'b100, 3'b100, 1, 0, 64'h0,         2, 3'b100, 1, 3'b000, 64'h0,        0);
        tv[10] = mk(0, 3'b001, 3'b000, 1, 0, 64'h0,         0, 3'b000, 0, 3'b000, 64'h0,        0);
        tv[11] = mk(0, 3'b001, 3'b000, 1, 1, 64'h55,        0, 3'b001, 1, 3'b100, 64'h55,       0);
        tv[12] = mk(0, 3'b000, 3'b000, 1, 1, 64'h66,       -1, 3'b000, 0, 3'b001, 64'h66,       0);
        tv[13] = mk(0, 3'b000, 3'b000, 1, 1, 64'h77,       -1, 3'b000, 0, 3'b001, 64'h77,       0);
        tv[14] = mk(0, 3'b100, 3'b100, 1, 0, 64'h0,         2, 3'b100, 1, 3'b000, 64'h0,        0);
        tv[15] = mk(0, 3'b011, 3'b000, 0, 0, 64'h0,         0, 3'b000, 1, 3'b000, 64'h0,        0);
        tv[16] = mk(0, 3'b011, 3'b000, 0, 0, 64'h0,         0, 3'b000, 1, 3'b000, 64'h0,        0);
        tv[17] = mk(0, 3'b011, 3'b000, 0, 0, 64'h0,         0, 3'b000, 1, 3'b000, 64'h0,        0);
        tv[18] = mk(0, 3'b011, 3'b000, 1, 0, 64'h0,         0, 3'b001, 1, 3'b000, 64'h0,        0);
        tv[19] = mk(0, 3'b010, 3'b000, 1, 0, 64'h0,         1, 3'b010, 1, 3'b000, 64'h0,        0);
        tv[20] = mk(1, 3'b000, 3'b000, 1, 0, 64'h0,        -1, 3'b000, 0, 3'b000, 64'h0,        0);
        tv[21] = mk(0, 3'b000, 3'b000, 1, 1, 64'h88,       -1, 3'b000, 0, 3'b000, 64'h0,        1);
        tv[22] = mk(0, 3'b000, 3'b000, 1, 1, 64'h89,       -1, 3'b000, 0, 3'b000, 64'h0,        1);
        tv[23] = mk(0, 3'b110, 3'b000, 1, 0, 64'h0,         1, 3'b010, 1, 3'b000, 64'h0,        0);
        tv[24] = mk(0, 3'b100, 3'b000, 1, 1, 64'h99,        2, 3'b100, 1, 3'b010, 64'h99,       0);
        tv[25] = mk(0, 3'b000, 3'b000, 1, 1, 64'hAA,       -1, 3'b000, 0, 3'b100, 64'hAA,       0);

        rst_i            = 1'b1;
        bus.req_valid_i  = '0;
        bus.req_we_i     = '0;
        bus.req_addr_i   = {addr_c[2], addr_c[1], addr_c[0]};
        bus.req_be_i     = {be_c[2], be_c[1], be_c[0]};
        bus.req_wdata_i  = {wdata_c[2], wdata_c[1], wdata_c[0]};
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            rst_i            = tv[i].rst;
            bus.req_valid_i  = tv[i].valid;
            bus.req_we_i     = tv[i].we;
            bus.mem_gnt_i    = tv[i].gnt;
            bus.mem_rvalid_i = tv[i].rvalid;
            bus.mem_rdata_i  = tv[i].rdata;
            #2;
            chk("req_gnt",   i, 64'(bus.req_gnt_o),   64'(tv[i].e_gnt));
            chk("mem_req",   i, 64'(bus.mem_req_o),   64'(tv[i].e_req));
            chk("mem_addr",  i, bus.mem_addr_o,
                (tv[i].e_port < 0) ? 64'h0 : addr_c[tv[i].e_port]);
            chk("mem_we",    i, 64'(bus.mem_we_o),
                (tv[i].e_port < 0) ? 64'h0 : 64'(tv[i].we[tv[i].e_port]));
            chk("mem_be",    i, 64'(bus.mem_be_o),
                (tv[i].e_port < 0) ? 64'h0 : 64'(be_c[tv[i].e_port]));
            chk("mem_wdata", i, bus.mem_wdata_o,
                (tv[i].e_port < 0) ? 64'h0 : wdata_c[tv[i].e_port]);
            chk("rsp_valid", i, 64'(bus.rsp_valid_o), 64'(tv[i].e_rsp));
            chk("rsp_rdata", i, bus.rsp_rdata_o,      tv[i].e_rdata);
            chk("orphan",    i, 64'(bus.orphan_rsp_o), 64'(tv[i].e_orphan));
        end

        // Load unit read with a delayed downstream grant; grant must pass
        // through in the same cycle mem_gnt_i rises.
        dly = int'($urandom_range(1, 3));
        got = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            bus.req_valid_i  = 3'b010;
            bus.req_we_i     = 3'b000;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_gnt_i    = (c >= dly);
            #2;
            if (bus.req_gnt_o == 3'b010) begin
                got = c;
                break;
            end
        end
        chk("hs_gnt_cycle", 100, 64'(got), 64'(dly));
        @(negedge clk_i);
        bus.req_valid_i  = 3'b000;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 64'hCAFE_F00D;
        #2;
        chk("hs_rsp_valid", 101, 64'(bus.rsp_valid_o), 64'(3'b010));
        chk("hs_rsp_rdata", 101, bus.rsp_rdata_o, 64'hCAFE_F00D);
        chk("hs_orphan",    101, 64'(bus.orphan_rsp_o), 64'h0);
        @(negedge clk_i);
        bus.mem_rvalid_i = 1'b0;
        #2;
        chk("hs_idle_rsp", 102, 64'(bus.rsp_valid_o), 64'h0);

`ifdef DCACHE_PORT_ARBITER_PERF_EN
        // Two writers contend for four cycles, then the loser finishes alone.
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #2;
        chk("perf_reset", 200, 64'(conflict_cnt), 64'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            bus.req_valid_i = 3'b011;
            bus.req_we_i    = 3'b011;
            bus.mem_gnt_i   = 1'b1;
        end
        @(negedge clk_i);
        bus.req_valid_i = 3'b001;
        #2;
        chk("perf_last_gnt", 201, 64'(bus.req_gnt_o), 64'(3'b001));
        @(negedge clk_i);
        bus.req_valid_i = 3'b000;
        bus.req_we_i    = 3'b000;
        #2;
        chk("perf_count", 202, 64'(conflict_cnt), 64'd4);
`endif

        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares one write-through data-cache request port between NrPorts requesters: port 0 = PTW, port 1 = load unit, port 2 = vector load/store unit.
- Round-robin arbitration on a valid/gnt request handshake.
- Tracks outstanding reads in an in-order ID FIFO and steers each read response back to the port that issued it.
- Sits between the ex_stage/MMU/vector clients and the WT dcache in the 64-bit, Sv39, RVV-enabled core.

Parameters:
- NrPorts, 3, number of requesters (2..8).
- AddrWidth, 64, request address width.
- DataWidth, 64, write and read data width; byte-enable width is DataWidth/8.
- MaxOutstanding, 2, depth of the outstanding-read ID FIFO (equals the load-buffer entry count).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  NrPorts  per-port request valid.
- req_addr_i  in  NrPorts*AddrWidth  per-port address.
- req_we_i  in  NrPorts  per-port write enable (1 = write).
- req_be_i  in  NrPorts*DataWidth/8  per-port byte enables.
- req_wdata_i  in  NrPorts*DataWidth  per-port write data.
- req_gnt_o  out  NrPorts  one-hot grant.
- mem_req_o  out  1  downstream request valid.
- mem_addr_o  out  AddrWidth  downstream address.
- mem_we_o  out  1  downstream write enable.
- mem_be_o  out  DataWidth/8  downstream byte enables.
- mem_wdata_o  out  DataWidth  downstream write data.
- mem_gnt_i  in  1  downstream grant.
- mem_rvalid_i  in  1  read response valid.
- mem_rdata_i  in  DataWidth  read response data.
- rsp_valid_o  out  NrPorts  one-hot response valid.
- rsp_rdata_o  out  DataWidth  response data, shared by all ports.
- orphan_rsp_o  out  1  one-cycle pulse: response arrived with the FIFO empty.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - round-robin pointer rr_q := 0; FIFO read pointer, write pointer and count := 0; orphan_rsp_o := 0.
  - All combinational outputs are 0 while the FIFO is empty and no port is valid.
- Requester handshake:
  - A requester holds valid, addr, we, be and wdata stable until it sees req_gnt_o.
  - Transfer occurs in any cycle with valid & gnt.
- Arbitration (combinational, same cycle):
  - Winner = first port with valid, searching from rr_q upward and wrapping modulo NrPorts.
  - mem_* = winner's fields; fields are 0 when there is no winner.
- Issue gating: mem_req_o = any_valid & (winner_we | !fifo_full | mem_rvalid_i).
  - A pop in the same cycle frees a slot, so a full FIFO with simultaneous rvalid still issues.
  - Writes never wait on the FIFO.
- Grant: req_gnt_o[winner] = mem_req_o & mem_gnt_i. Zero-cycle latency from mem_gnt_i to req_gnt_o.
- rr_q update:
  - On a granted transfer, rr_q := (winner+1) mod NrPorts.
  - Otherwise rr_q holds. A winner that is not granted keeps the pointer, so no starvation.
- Outstanding FIFO:
  - Granted read (we=0): push winner index (clog2(NrPorts) bits).
  - Granted write: no push; writes produce no rvalid.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo MaxOutstanding; count ranges 0..MaxOutstanding.
- Response routing (combinational):
  - If mem_rvalid_i & !fifo_empty: rsp_valid_o[head] = 1, rsp_rdata_o = mem_rdata_i, pop.
  - Responses return in order.
- Orphan response: mem_rvalid_i & fifo_empty drives rsp_valid_o = 0, raises orphan_rsp_o for that cycle, and leaves state unchanged.
  - Covers a response arriving after reset mid-operation; such responses are dropped.
- Reset mid-operation: in-flight reads are forgotten. Requesters are reset in the same cycle by the same reset.
- Assertions:
  - Push when full with no pop never occurs.
  - req_gnt_o is onehot0.
  - Request fields stay stable while valid and not granted.

Optional Feature:
- Macro: DCACHE_PORT_ARBITER_PERF_EN.
- When defined, adds output port conflict_cnt_o (32 bits): per-cycle saturating count of cycles where two or more ports are valid and at least one is not granted. It clears on rst_i.
- When undefined, the port and the counter are absent.

Decomposition:
- Shared package dcache_arb_pkg:
  - port index typedef port_idx_t, with width clog2(NrPorts).
  - constants PORT_PTW=0, PORT_LOAD=1, PORT_VLSU=2.
- One sub-module: dcache_arb_id_fifo, a MaxOutstanding-deep fifo of port_idx_t with push, pop, full, empty and head outputs.
- Round-robin select stays inline.

Test Plan:
- All three ports valid, mem_gnt_i=1 every cycle, reads only -> grants in order 0,1,2,0; responses returned one cycle later go to rsp_valid_o 001,010,100 in that order.
- Port 1 read granted, then port 2 read granted (FIFO full at 2), then port 0 requests with no rvalid -> mem_req_o=0 and no grant. Asserting rvalid in that same cycle -> port 0 granted; response to port 1 carries rdata 0xDEAD_BEEF.
- FIFO full, port 2 issues a write with be=0xFF -> granted immediately; FIFO count stays 2.
- Port 0 valid, mem_gnt_i=0 for 3 cycles while port 1 also valid -> rr_q stays, port 0 remains winner with stable fields, and port 0 is granted first when mem_gnt_i=1.
- Two reads outstanding, rst_i pulsed for 1 cycle, then mem_rvalid_i=1 -> orphan_rsp_o=1, rsp_valid_o=0, count stays 0.
- With DCACHE_PORT_ARBITER_PERF_EN defined: ports 0 and 1 valid for 4 cycles with mem_gnt_i=1 -> conflict_cnt_o=4.
